// File: rtl/fetch_branch_predictor_pkg.sv
// Shared predictor types: 2-bit direction counter encoding, BTB entry layout, saturating counter step.
// Pure types/functions; no timing or flow control of its own.
package utils_top;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_t;

  // Tag field sized for the smallest legal table (4 entries); larger tables leave upper bits zero.
  localparam int TAG_MAX_W = 28;

  typedef struct packed {
    bht_cnt_t               cnt;
    logic                   vld;
    logic [TAG_MAX_W-1:0]   tag;
    logic [29:0]            tgt;
  } btb_entry_t;

  function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = bht_cnt_t'(cnt + 2'd1);
    end else begin
      if (cnt != SNT) nxt = bht_cnt_t'(cnt - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_branch_predictor_sat_counter.sv
// Saturating perf counter: 1-cycle increment, sticks at all-ones, synchronous clear.
// No backpressure; inc is sampled every cycle.
module bp_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_branch_predictor.sv
// Fetch direction/target predictor (2-bit BHT + tagged direct-mapped BTB), lookup latency 1, update visible next cycle.
// ftch_stall holds the registered prediction; flush clears it and overrides stall.
module fetch_branch_predictor
  import utils_top::*;
#(
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ftch_vld,
  input  logic             ftch_stall,
  input  logic [31:0]      ftch_pc,
  input  logic             flush,
  output logic             pred_vld,
  output logic             pred_taken,
  output logic [31:0]      pred_tgt,
  input  logic             upd_vld,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_tgt,
  input  logic             upd_mispred,
  output logic [CNT_W-1:0] perf_lookups,
  output logic [CNT_W-1:0] perf_mispred
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  btb_entry_t r_tbl [BHT_DEPTH];

  logic                 r_pred_vld;
  logic                 r_pred_taken;
  logic [31:0]          r_pred_tgt;

  logic [IDX_W-1:0]     w_lk_idx;
  logic [TAG_MAX_W-1:0] w_lk_tag;
  logic [IDX_W-1:0]     w_up_idx;
  logic [TAG_MAX_W-1:0] w_up_tag;
  btb_entry_t           w_lk_ent;
  logic                 w_lk_taken;
  logic                 w_lookup;
  logic                 w_mispred_inc;
  logic                 w_unused_bits;

  assign w_lk_idx   = ftch_pc[IDX_W+1:2];
  assign w_lk_tag   = TAG_MAX_W'(ftch_pc[31:IDX_W+2]);
  assign w_up_idx   = upd_pc[IDX_W+1:2];
  assign w_up_tag   = TAG_MAX_W'(upd_pc[31:IDX_W+2]);
  assign w_lk_ent   = r_tbl[w_lk_idx];
  assign w_lk_taken = w_lk_ent.vld && (w_lk_ent.tag == w_lk_tag) && w_lk_ent.cnt[1];
  assign w_lookup   = ftch_vld && !ftch_stall && !flush;
  assign w_mispred_inc = upd_vld && upd_mispred;
  assign w_unused_bits = ^{ftch_pc[1:0], upd_pc[1:0], upd_tgt[1:0]};

  // Priority: reset, flush, stall hold, then fresh lookup or idle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pred_vld   <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_tgt   <= '0;
    end else if (flush) begin
      r_pred_vld   <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_tgt   <= '0;
    end else if (!ftch_stall) begin
      r_pred_vld   <= ftch_vld;
      r_pred_taken <= ftch_vld && w_lk_taken;
      r_pred_tgt   <= (ftch_vld && w_lk_taken) ? {w_lk_ent.tgt, 2'b00} : 32'h0;
    end
  end

  // Counter trains on every resolution; BTB fields are only written on taken outcomes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_tbl[i].cnt <= WNT;
        r_tbl[i].vld <= 1'b0;
        r_tbl[i].tag <= '0;
        r_tbl[i].tgt <= '0;
      end
    end else if (upd_vld) begin
      r_tbl[w_up_idx].cnt <= bht_next(r_tbl[w_up_idx].cnt, upd_taken);
      if (upd_taken) begin
        r_tbl[w_up_idx].vld <= 1'b1;
        r_tbl[w_up_idx].tag <= w_up_tag;
        r_tbl[w_up_idx].tgt <= upd_tgt[31:2];
      end
    end
  end

  bp_sat_counter #(.W(CNT_W)) u_perf_lookups (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (w_lookup),
    .i_clr (1'b0),
    .o_cnt (perf_lookups)
  );

  bp_sat_counter #(.W(CNT_W)) u_perf_mispred (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (w_mispred_inc),
    .i_clr (1'b0),
    .o_cnt (perf_mispred)
  );

  assign pred_vld   = r_pred_vld;
  assign pred_taken = r_pred_taken;
  assign pred_tgt   = r_pred_tgt;

endmodule

// File: tb/tb_fetch_branch_predictor.sv
// Scoreboard bench: stimulus pushes expected next-cycle outputs; a monitor pops and compares each cycle.
module tb_fetch_branch_predictor;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ftch_vld = 1'b0, ftch_stall = 1'b0, flush = 1'b0;
  logic [31:0] ftch_pc = '0;
  logic        pred_vld, pred_taken;
  logic [31:0] pred_tgt;
  logic        upd_vld = 1'b0, upd_taken = 1'b0, upd_mispred = 1'b0;
  logic [31:0] upd_pc = '0, upd_tgt = '0;
  logic [3:0]  perf_lookups, perf_mispred;

  fetch_branch_predictor #(.BHT_DEPTH(64), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn),
    .ftch_vld(ftch_vld), .ftch_stall(ftch_stall), .ftch_pc(ftch_pc), .flush(flush),
    .pred_vld(pred_vld), .pred_taken(pred_taken), .pred_tgt(pred_tgt),
    .upd_vld(upd_vld), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_tgt(upd_tgt),
    .upd_mispred(upd_mispred),
    .perf_lookups(perf_lookups), .perf_mispred(perf_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        v;
    logic        t;
    logic [31:0] tgt;
    logic [3:0]  lk;
    logic [3:0]  mp;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [3:0] mdl_lk = 4'h0;
  logic [3:0] mdl_mp = 4'h0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
    end
  endtask

  // Monitor: outputs reflect the stimulus applied before the preceding edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.nm, " pred_vld"},     {31'b0, pred_vld},   {31'b0, e.v});
        check({e.nm, " pred_taken"},   {31'b0, pred_taken}, {31'b0, e.t});
        check({e.nm, " pred_tgt"},     pred_tgt,            e.tgt);
        check({e.nm, " perf_lookups"}, {28'b0, perf_lookups}, {28'b0, e.lk});
        check({e.nm, " perf_mispred"}, {28'b0, perf_mispred}, {28'b0, e.mp});
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic fv, input logic fs,
                      input logic fl, input logic [31:0] fpc, input logic uv,
                      input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                      input logic um, input logic ev, input logic et, input logic [31:0] etgt);
    exp_t e;
    @(negedge clk);
    rstn = rst; ftch_vld = fv; ftch_stall = fs; flush = fl; ftch_pc = fpc;
    upd_vld = uv; upd_pc = upc; upd_taken = ut; upd_tgt = utgt; upd_mispred = um;
    if (!rst) begin
      mdl_lk = 4'h0;
      mdl_mp = 4'h0;
    end else begin
      if (fv && !fs && !fl && mdl_lk != 4'hF) mdl_lk = mdl_lk + 4'h1;
      if (uv && um && mdl_mp != 4'hF) mdl_mp = mdl_mp + 4'h1;
    end
    e.nm = nm; e.v = ev; e.t = et; e.tgt = etgt; e.lk = mdl_lk; e.mp = mdl_mp;
    q.push_back(e);
  endtask

  task automatic lookup(input string nm, input logic [31:0] pc, input logic et,
                        input logic [31:0] etgt);
    step(nm, 1'b1, 1'b1, 1'b0, 1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, et, etgt);
  endtask

  task automatic update(input string nm, input logic [31:0] pc, input logic t,
                        input logic [31:0] tgt, input logic m);
    step(nm, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, pc, t, tgt, m, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    step("reset0", 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1,
         1'b0, 1'b0, 32'h0);
    step("reset1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
         1'b0, 1'b0, 32'h0);

    lookup("cold", 32'h100, 1'b0, 32'h0);
    update("up_t1", 32'h100, 1'b1, 32'h200, 1'b1);   // WNT->WT
    update("up_t2", 32'h100, 1'b1, 32'h200, 1'b0);   // WT->ST
    lookup("hit_st", 32'h100, 1'b1, 32'h200);
    lookup("alias", 32'h200, 1'b0, 32'h0);

    update("nt1", 32'h100, 1'b0, 32'h0, 1'b1);       // ST->WT
    lookup("hit_wt", 32'h100, 1'b1, 32'h200);
    update("nt2", 32'h100, 1'b0, 32'h0, 1'b1);       // WT->WNT
    lookup("hit_wnt", 32'h100, 1'b0, 32'h0);
    update("nt3", 32'h100, 1'b0, 32'h0, 1'b0);       // WNT->SNT
    update("nt4", 32'h100, 1'b0, 32'h0, 1'b0);       // stays SNT
    lookup("hit_snt", 32'h100, 1'b0, 32'h0);
    update("t_from_snt", 32'h100, 1'b1, 32'h200, 1'b0);  // SNT->WNT
    lookup("still_nt", 32'h100, 1'b0, 32'h0);
    update("t_to_wt", 32'h100, 1'b1, 32'h200, 1'b0);     // WNT->WT
    lookup("back_wt", 32'h100, 1'b1, 32'h200);

    // Same-cycle update (WT->WNT) and lookup: old prediction, new one next cycle.
    step("same_cyc", 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0,
         1'b1, 1'b1, 32'h200);
    lookup("after_same", 32'h100, 1'b0, 32'h0);

    update("retarget", 32'h100, 1'b1, 32'h300, 1'b0);    // WNT->WT, tgt 0x300
    lookup("pre_stall", 32'h100, 1'b1, 32'h300);
    step("stall_v", 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
         1'b1, 1'b1, 32'h300);
    step("stall_nv", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
         1'b1, 1'b1, 32'h300);
    step("flush_stall", 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
         1'b0, 1'b0, 32'h0);
    step("idle", 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
         1'b0, 1'b0, 32'h0);

    // Drive both perf counters into saturation; 0x104 trains a different index only.
    for (int i = 0; i < 14; i++) begin
      step("sat", 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 32'h104, 1'b0, 32'h0, 1'b1,
           1'b1, 1'b1, 32'h300);
    end

    step("mid_reset", 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h500, 1'b1,
         1'b0, 1'b0, 32'h0);
    lookup("post_rst", 32'h100, 1'b0, 32'h0);
    update("post_rst_t", 32'h100, 1'b1, 32'h400, 1'b0);  // WNT->WT if reinitialised
    lookup("post_rst_hit", 32'h100, 1'b1, 32'h400);
    step("drain", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
         1'b0, 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
